// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, default sizing
// constants and the wait-counter width helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_e;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W_DEF   = 16;

    // Wait counter must hold TIMEOUT and is never narrower than 8 bits.
    function automatic int unsigned wait_cnt_w(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous clear,
// used for the hazard unit's performance counters.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait holds with timeout to a sticky error state, plus stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             pipe_hold_o,
    output logic             memwb_bubble_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned       WAIT_W    = wait_cnt_w(TIMEOUT);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              load_use;
    logic              mem_miss;
    logic              stall_inc;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = idex_memread_i && (idex_rd_i != 5'd0) &&
                      ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
    assign mem_miss = dmem_req_i && !dmem_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (mem_miss) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_d = ST_RUN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == TIMEOUT_C) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RUN;
        endcase
    end

    // Reset is folded into the decode so outputs show RUN defaults while held.
    always_comb begin
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        pipe_hold_o    = 1'b0;
        memwb_bubble_o = 1'b0;
        mem_err_o      = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_miss) begin
                        pc_write_o     = 1'b0;
                        ifid_write_o   = 1'b0;
                        pipe_hold_o    = 1'b1;
                        memwb_bubble_o = 1'b1;
                    end else if (branch_taken_i) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!dmem_ready_i) begin
                        pc_write_o     = 1'b0;
                        ifid_write_o   = 1'b0;
                        pipe_hold_o    = 1'b1;
                        memwb_bubble_o = 1'b1;
                    end else if (branch_taken_i) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end
                end
                ST_ERROR: begin
                    pc_write_o     = 1'b0;
                    ifid_write_o   = 1'b0;
                    pipe_hold_o    = 1'b1;
                    memwb_bubble_o = 1'b1;
                    mem_err_o      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stall_inc = !pc_write_o && (state_q != ST_ERROR);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ifid_flush_o),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl with short timeout and 4-bit counters, using
// directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          memread = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic          pc_w, ifid_w, ifid_fl, idex_fl, hold, bub, err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    obs;
    logic [6:0]    exp_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: "waiting on memory", "errored", waited cycles, counters.
    bit m_wait, m_err;
    int m_wcnt, m_stall, m_flush;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .idex_memread_i (memread),
        .idex_rd_i      (rd),
        .ifid_rs1_i     (rs1),
        .ifid_rs2_i     (rs2),
        .branch_taken_i (br),
        .dmem_req_i     (req),
        .dmem_ready_i   (rdy),
        .pc_write_o     (pc_w),
        .ifid_write_o   (ifid_w),
        .ifid_flush_o   (ifid_fl),
        .idex_flush_o   (idex_fl),
        .pipe_hold_o    (hold),
        .memwb_bubble_o (bub),
        .mem_err_o      (err),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, mem_err}
    assign obs = {pc_w, ifid_w, ifid_fl, idex_fl, hold, bub, err};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [6:0] model_eval();
        logic lu;
        lu = memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        if (rst)             return 7'b1100000;
        if (m_err)           return 7'b0000111;
        if (m_wait) begin
            if (!rdy)        return 7'b0000110;
            return br ? 7'b1111000 : 7'b1100000;
        end
        if (req && !rdy)     return 7'b0000110;
        if (br)              return 7'b1111000;
        if (lu)              return 7'b0001000;
        return 7'b1100000;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_step(input logic [6:0] e);
        if (!m_err && !e[6] && m_stall < CMAX) m_stall++;
        if (e[4] && m_flush < CMAX) m_flush++;
        if (m_err) begin
        end else if (m_wait) begin
            if (rdy) m_wait = 0;
            else begin
                m_wcnt++;
                if (m_wcnt == TO) begin m_err = 1; m_wait = 0; end
            end
        end else if (req && !rdy) begin
            m_wait = 1; m_wcnt = 0;
        end
    endtask

    task automatic idle_inputs();
        memread = 0; br = 0; req = 0; rdy = 0; rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        exp_o = model_eval();
    endtask

    task automatic advance();
        model_step(exp_o);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        memread = 1; rd = 5'd7; rs1 = 5'd7; req = 1; rdy = 0; br = 1;
        #2;
        model_reset();
        n_cmp++;
        if (obs !== 7'b1100000) begin
            n_fail++; $display("FAIL reset_ctl: got %b required %b", obs, 7'b1100000);
        end
        n_cmp++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        settle();
        n_cmp++;
        if (obs !== 7'b1100000) begin
            n_fail++; $display("FAIL post_reset_ctl: got %b required %b", obs, 7'b1100000);
        end
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        memread = 1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd9;
        settle();
        n_cmp++;
        if (obs !== 7'b0001000 || obs !== exp_o) begin
            n_fail++; $display("FAIL load_use_ctl: got %b required %b", obs, 7'b0001000);
        end
        advance();
        idle_inputs();
        settle();
        n_cmp++;
        if (stall_cnt !== CW'(1) || obs !== 7'b1100000) begin
            n_fail++; $display("FAIL load_use_cnt: got %0d %b required 1 1100000", stall_cnt, obs);
        end
        advance();
        memread = 1; rd = 5'd12; rs1 = 5'd3; rs2 = 5'd12;
        settle();
        n_cmp++;
        if (obs !== exp_o || pc_w !== 1'b0) begin
            n_fail++; $display("FAIL load_use_rs2: got %b required %b", obs, exp_o);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_load_x0();
        do_reset();
        memread = 1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        settle();
        n_cmp++;
        if (obs !== 7'b1100000) begin
            n_fail++; $display("FAIL load_x0_ctl: got %b required %b", obs, 7'b1100000);
        end
        advance();
        settle();
        n_cmp++;
        if (stall_cnt !== '0) begin
            n_fail++; $display("FAIL load_x0_cnt: got %0d required 0", stall_cnt);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        req = 1; rdy = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++;
            if (obs !== 7'b0000110) begin
                n_fail++; $display("FAIL mem_wait_hold%0d: got %b required %b", i, obs, 7'b0000110);
            end
            advance();
        end
        rdy = 1;
        settle();
        n_cmp++;
        if (obs !== 7'b1100000) begin
            n_fail++; $display("FAIL mem_wait_release: got %b required %b", obs, 7'b1100000);
        end
        advance();
        idle_inputs();
        settle();
        n_cmp++;
        if (stall_cnt !== CW'(3) || obs !== 7'b1100000) begin
            n_fail++; $display("FAIL mem_wait_cnt: got %0d %b required 3 1100000", stall_cnt, obs);
        end
        advance();
        req = 1; rdy = 1; memread = 0;
        settle();
        n_cmp++;
        if (obs !== 7'b1100000) begin
            n_fail++; $display("FAIL zero_wait_ctl: got %b required %b", obs, 7'b1100000);
        end
        advance();
        idle_inputs();
        settle();
        n_cmp++;
        if (stall_cnt !== CW'(3)) begin
            n_fail++; $display("FAIL zero_wait_cnt: got %0d required 3", stall_cnt);
        end
        advance();
    endtask

    task automatic test_branch_load_use();
        do_reset();
        memread = 1; rd = 5'd5; rs1 = 5'd5; br = 1;
        settle();
        n_cmp++;
        if (obs !== 7'b1111000) begin
            n_fail++; $display("FAIL branch_lu_ctl: got %b required %b", obs, 7'b1111000);
        end
        advance();
        idle_inputs();
        settle();
        n_cmp++;
        if (flush_cnt !== CW'(1) || stall_cnt !== '0) begin
            n_fail++; $display("FAIL branch_lu_cnt: got %0d/%0d required 1/0", flush_cnt, stall_cnt);
        end
        advance();
        req = 1; rdy = 0;
        settle();
        advance();
        rdy = 1; br = 1;
        settle();
        n_cmp++;
        if (obs !== 7'b1111000) begin
            n_fail++; $display("FAIL wait_branch_ctl: got %b required %b", obs, 7'b1111000);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 1; rdy = 0;
        for (int i = 0; i <= TO; i++) begin
            settle();
            n_cmp++;
            if (err !== 1'b0 || hold !== 1'b1) begin
                n_fail++; $display("FAIL timeout_pre%0d: got err=%b hold=%b required 0 1", i, err, hold);
            end
            advance();
        end
        settle();
        n_cmp++;
        if (obs !== 7'b0000111 || stall_cnt !== CW'(TO + 1)) begin
            n_fail++; $display("FAIL timeout_err: got %b cnt %0d required 0000111 cnt %0d", obs, stall_cnt, TO + 1);
        end
        advance();
        req = 0; rdy = 1; br = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++;
            if (err !== 1'b1 || stall_cnt !== CW'(TO + 1) || flush_cnt !== '0) begin
                n_fail++; $display("FAIL timeout_sticky%0d: got err=%b cnt=%0d/%0d required 1 %0d/0",
                                   i, err, stall_cnt, flush_cnt, TO + 1);
            end
            advance();
        end
        idle_inputs();
        do_reset();
        settle();
        n_cmp++;
        if (err !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0 || obs !== 7'b1100000) begin
            n_fail++; $display("FAIL timeout_clear: got err=%b cnt=%0d/%0d required 0 0/0", err, stall_cnt, flush_cnt);
        end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        memread = 1; rd = 5'd3; rs2 = 5'd3; rs1 = 5'd1;
        for (int i = 0; i < 20; i++) begin
            settle();
            advance();
        end
        idle_inputs();
        settle();
        n_cmp++;
        if (stall_cnt !== CW'(CMAX)) begin
            n_fail++; $display("FAIL saturation: got %0d required %0d", stall_cnt, CMAX);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_err || $urandom_range(0, 49) == 0) begin
                idle_inputs();
                do_reset();
            end
            memread = ($urandom_range(0, 2) == 0);
            rd  = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            br  = ($urandom_range(0, 3) == 0);
            req = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            settle();
            n_cmp++;
            if (obs !== exp_o || stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
                n_fail++; $display("FAIL random%0d: got %b %0d/%0d required %b %0d/%0d",
                                   i, obs, stall_cnt, flush_cnt, exp_o, m_stall, m_flush);
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_load_x0();
        test_mem_wait();
        test_branch_load_use();
        test_timeout();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum MEM_WAIT cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port idex_memread_i, input, 1: the instruction in EX is a load.
REQ-006 SHALL have port idex_rd_i, input, 5: destination register of the instruction in EX.
REQ-007 SHALL have ports ifid_rs1_i and ifid_rs2_i, input, 5 each: source registers of the instruction in ID.
REQ-008 SHALL have port branch_taken_i, input, 1: EX resolved a taken branch or jump.
REQ-009 SHALL have port dmem_req_i, input, 1: MEM stage is accessing data memory.
REQ-010 SHALL have port dmem_ready_i, input, 1: data memory has completed the access.
REQ-011 SHALL have outputs pc_write_o and ifid_write_o, 1 each: load enables for PC and IF/ID.
REQ-012 SHALL have outputs ifid_flush_o and idex_flush_o, 1 each: load a bubble into IF/ID and ID/EX.
REQ-013 SHALL have output pipe_hold_o, 1: hold ID/EX and EX/MEM contents.
REQ-014 SHALL have output memwb_bubble_o, 1: load zeros into the MEM/WB WB control field.
REQ-015 SHALL have output mem_err_o, 1: sticky memory-timeout error.
REQ-016 SHALL have outputs stall_cnt_o and flush_cnt_o, CNT_W each: performance counters.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT and ERROR; all outputs are a combinational decode of the state and inputs.
REQ-018 RUN default outputs: pc_write_o=1, ifid_write_o=1, all other controls 0.
REQ-019 RUN, dmem_req_i=1 and dmem_ready_i=0: go to MEM_WAIT and, in the same cycle, drive pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, memwb_bubble_o=1; this takes priority over the branch and load-use cases.
REQ-020 RUN, no memory wait, branch_taken_i=1: drive ifid_flush_o=1, idex_flush_o=1, pc_write_o=1; the branch case overrides load-use.
REQ-021 RUN, load-use case (idex_memread_i=1, idex_rd_i!=0, and idex_rd_i equals ifid_rs1_i or ifid_rs2_i): drive pc_write_o=0, ifid_write_o=0, idex_flush_o=1 for exactly that cycle.
REQ-022 MEM_WAIT: drive the same outputs as REQ-019 each cycle; the wait counter increments each cycle.
REQ-023 MEM_WAIT, dmem_ready_i=1: output RUN defaults for that cycle and return to RUN next edge; a pending branch_taken_i is then honoured per REQ-020 in that cycle.
REQ-024 MEM_WAIT, wait counter reaches TIMEOUT without dmem_ready_i: go to ERROR.
REQ-025 ERROR: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, memwb_bubble_o=1, mem_err_o=1; remains in ERROR until reset.
REQ-026 The wait counter SHALL be 8 bits or more, sized from TIMEOUT, and clear on every entry into MEM_WAIT.
REQ-027 stall_cnt_o SHALL increment each cycle pc_write_o=0 outside ERROR, saturating at all-ones.
REQ-028 flush_cnt_o SHALL increment each cycle ifid_flush_o=1, saturating at all-ones.
REQ-029 A zero-wait access (dmem_req_i=1 and dmem_ready_i=1 in RUN) SHALL cause no stall.

Reset
REQ-030 rst_i=1 SHALL immediately force state RUN, wait counter 0, both performance counters 0 and mem_err_o=0, including mid-MEM_WAIT and in ERROR.
REQ-031 During reset the outputs SHALL be the RUN defaults: pc_write_o=1, ifid_write_o=1, all else 0.
REQ-032 After rst_i deasserts, the first rising edge SHALL operate normally.

Structure
REQ-033 The FSM state encoding and the default TIMEOUT/CNT_W constants SHALL reside in the shared pipeline package.
REQ-034 A sub-module sat_counter (parameterised width, increment enable, async clear) SHALL be used for both performance counters; all other logic is flat.

Verification
REQ-035 Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs1_i=5 -> one cycle of pc_write_o=0, idex_flush_o=1, stall_cnt_o=1.
REQ-036 Load to x0: idex_rd_i=0, ifid_rs1_i=0 -> no stall, stall_cnt_o stays 0.
REQ-037 Memory wait: dmem_req_i=1 with dmem_ready_i low for 3 cycles -> pipe_hold_o=1 for 3 cycles, then RUN; stall_cnt_o=3.
REQ-038 Branch concurrent with load-use -> ifid_flush_o=1, idex_flush_o=1, pc_write_o=1, flush_cnt_o=1.
REQ-039 Timeout: TIMEOUT=4 and dmem_ready_i never asserted -> mem_err_o=1 after 4 wait cycles and stays set until rst_i pulses, after which all counters read 0.
REQ-040 Saturation: CNT_W=4 and 20 stall cycles -> stall_cnt_o holds at 15.
